// File: rtl/control_pkg.sv
// lc3b_types: LC-3b opcode and ALU operation types shared by control and datapath
package lc3b_types;
  typedef enum logic [3:0] {
    op_br  = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb = 4'b0011,
    op_jsr = 4'b0100, op_and = 4'b0101, op_ldr = 4'b0110, op_str = 4'b0111,
    op_rti = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti = 4'b1011,
    op_jmp = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
  } lc3b_opcode;
  typedef enum logic [2:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
  } lc3b_aluop;
endpackage

// File: rtl/control_if.sv
// control_if: control <-> datapath/memory bundle; master = control unit, slave = datapath side
//   opcode, branch_enable, mem_resp : datapath/memory -> control
//   load_*, *mux_sel, aluop         : control -> datapath
//   mem_read, mem_write, mem_byte_enable : control -> memory
interface control_if;
  import lc3b_types::*;
  lc3b_opcode opcode;
  logic branch_enable, mem_resp;
  logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel;
  lc3b_aluop aluop;
  logic mem_read, mem_write;
  logic [1:0] mem_byte_enable;
  modport master (
    input  opcode, branch_enable, mem_resp,
    output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
           pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel,
           aluop, mem_read, mem_write, mem_byte_enable
  );
  modport slave (
    output opcode, branch_enable, mem_resp,
    input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
           pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel,
           aluop, mem_read, mem_write, mem_byte_enable
  );
endinterface

// File: rtl/control.sv
// control: LC-3b multicycle Moore controller; clk, async active-low rst_n, bus (control_if.master)
module control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic rst_n,
  control_if.master bus
);
  typedef enum logic [3:0] {
    fetch1, fetch2, fetch3, decode, s_add, s_and, s_not, s_br, s_br_taken,
    s_calc_addr, s_ldr1, s_ldr2, s_str1, s_str2
  } state_t;
  state_t state, next_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= fetch1;
    else state <= next_state;
  // Outputs depend on state only, so an async reset shows FETCH1 values at once.
  always_comb begin
    next_state = state;
    bus.load_pc = 1'b0;
    bus.load_ir = 1'b0;
    bus.load_regfile = 1'b0;
    bus.load_mar = 1'b0;
    bus.load_mdr = 1'b0;
    bus.load_cc = 1'b0;
    bus.pcmux_sel = 1'b0;
    bus.storemux_sel = 1'b0;
    bus.alumux_sel = 1'b0;
    bus.regfilemux_sel = 1'b0;
    bus.marmux_sel = 1'b0;
    bus.mdrmux_sel = 1'b0;
    bus.aluop = alu_add;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_byte_enable = 2'b11;
    case (state)
      fetch1: begin
        bus.marmux_sel = 1'b1;
        bus.load_mar = 1'b1;
        bus.load_pc = 1'b1;
        next_state = fetch2;
      end
      fetch2, s_ldr1: begin
        bus.mem_read = 1'b1;
        bus.mdrmux_sel = 1'b1;
        bus.load_mdr = 1'b1;
        if (bus.mem_resp) next_state = state == fetch2 ? fetch3 : s_ldr2;
      end
      fetch3: begin
        bus.load_ir = 1'b1;
        next_state = decode;
      end
      decode:
        case (bus.opcode)
          op_add:         next_state = s_add;
          op_and:         next_state = s_and;
          op_not:         next_state = s_not;
          op_br:          next_state = s_br;
          op_ldr, op_str: next_state = s_calc_addr;
          default:        next_state = fetch1;
        endcase
      s_add, s_and, s_not: begin
        bus.aluop = state == s_add ? alu_add : state == s_and ? alu_and : alu_not;
        bus.load_regfile = 1'b1;
        bus.load_cc = 1'b1;
        next_state = fetch1;
      end
      s_br: next_state = bus.branch_enable ? s_br_taken : fetch1;
      s_br_taken: begin
        bus.pcmux_sel = 1'b1;
        bus.load_pc = 1'b1;
        next_state = fetch1;
      end
      s_calc_addr: begin
        bus.alumux_sel = 1'b1;
        bus.load_mar = 1'b1;
        next_state = bus.opcode == op_ldr ? s_ldr1 : s_str1;
      end
      s_ldr2: begin
        bus.regfilemux_sel = 1'b1;
        bus.load_regfile = 1'b1;
        bus.load_cc = 1'b1;
        next_state = fetch1;
      end
      s_str1: begin
        bus.storemux_sel = 1'b1;
        bus.aluop = alu_pass;
        bus.load_mdr = 1'b1;
        next_state = s_str2;
      end
      s_str2: begin
        bus.mem_write = 1'b1;
        if (bus.mem_resp) next_state = fetch1;
      end
      default: next_state = fetch1;
    endcase
  end
endmodule

// File: tb/tb_control.sv
// tb_control: randomized instruction streams checked against a per-instruction expected-output script
module tb_control;
  import lc3b_types::*;
  logic clk, rst_n;
  control_if bus ();
  control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vector: {load_pc,load_ir,load_regfile,load_mar,load_mdr,load_cc,pcmux,storemux,alumux,
  //          regfilemux,marmux,mdrmux,aluop[2:0],mem_read,mem_write,mem_byte_enable[1:0]}
  localparam logic [18:0] one = 19'd1;
  localparam logic [18:0] be_v = 19'd3;
  localparam logic [18:0] f1_v = be_v | one << 18 | one << 15 | one << 8;
  localparam logic [18:0] rd_v = be_v | one << 14 | one << 7 | one << 3;
  localparam logic [18:0] f3_v = be_v | one << 17;
  localparam logic [18:0] brt_v = be_v | one << 18 | one << 12;
  localparam logic [18:0] calc_v = be_v | one << 15 | one << 10;
  localparam logic [18:0] ldr2_v = be_v | one << 16 | one << 13 | one << 9;
  localparam logic [18:0] str1_v = be_v | one << 14 | one << 11 | 19'd3 << 4;
  localparam logic [18:0] wr_v = be_v | one << 2;

  typedef struct { logic [18:0] v; int r; } step_t;
  step_t q[$];
  int n_vec = 0, n_bad = 0;

  function automatic logic [18:0] alu_v(input int op);
    return be_v | one << 16 | one << 13 | 19'(op) << 4;
  endfunction

  function automatic logic [18:0] got();
    return {bus.load_pc, bus.load_ir, bus.load_regfile, bus.load_mar, bus.load_mdr, bus.load_cc,
            bus.pcmux_sel, bus.storemux_sel, bus.alumux_sel, bus.regfilemux_sel, bus.marmux_sel,
            bus.mdrmux_sel, 3'(bus.aluop), bus.mem_read, bus.mem_write, bus.mem_byte_enable};
  endfunction

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // r: 0 = mem_resp low, 1 = mem_resp high, 2 = random (response must be ignored)
  task automatic push(input logic [18:0] v, input int r, input int n);
    for (int k = 0; k < n; k++) q.push_back('{v, r});
  endtask

  task automatic run_instr(input int op, input bit br_en, input int w, input bit abort);
    int mark = -1;
    q.delete();
    push(f1_v, 2, 1); push(rd_v, 0, w); push(rd_v, 1, 1); push(f3_v, 2, 1); push(be_v, 2, 1);
    case (op)
      1: push(alu_v(0), 2, 1);
      5: push(alu_v(1), 2, 1);
      9: push(alu_v(2), 2, 1);
      0: begin push(be_v, 2, 1); if (br_en) push(brt_v, 2, 1); end
      6: begin
        push(calc_v, 2, 1); mark = q.size();
        push(rd_v, 0, w); push(rd_v, 1, 1); push(ldr2_v, 2, 1);
      end
      7: begin push(calc_v, 2, 1); push(str1_v, 2, 1); push(wr_v, 0, w); push(wr_v, 1, 1); end
      default: ;
    endcase
    bus.opcode = lc3b_opcode'(op);
    bus.branch_enable = br_en;
    for (int i = 0; i < q.size(); i++) begin
      if (abort && i == mark + 1) begin
        #2 rst_n = 1'b0;
        #1 check("async_reset", got(), f1_v);
        check("reset_mem_read", {18'd0, bus.mem_read}, 19'd0);
        #1 rst_n = 1'b1;
        return;
      end
      check($sformatf("op%0d_step%0d", op, i), got(), q[i].v);
      bus.mem_resp = q[i].r == 2 ? 1'($urandom) : q[i].r[0];
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.opcode = op_br;
    bus.branch_enable = 1'b0;
    bus.mem_resp = 1'b1;
    #3 check("reset_hold0", got(), f1_v);
    @(negedge clk);
    check("reset_hold1", got(), f1_v);
    rst_n = 1'b1;
    run_instr(1, 0, 0, 0);
    run_instr(1, 0, 4, 0);
    run_instr(0, 1, 1, 0);
    run_instr(0, 0, 0, 0);
    run_instr(7, 0, 3, 0);
    run_instr(6, 0, 2, 1);
    run_instr(15, 1, 0, 0);
    run_instr(6, 0, 0, 0);
    run_instr(5, 0, 2, 0);
    run_instr(9, 1, 1, 0);
    for (int n = 0; n < 300; n++)
      run_instr(int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 4)),
                $urandom_range(0, 19) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
